// File: rtl/pcie_link_pkg.sv
// Shared encodings for the PCIe directed link speed/width change sequencer.
package pcie_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_L0 = 3'd1,
    ST_ASSERT  = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_CHECK   = 3'd4
  } lc_state_t;

  localparam logic [2:0] STAT_NONE     = 3'd0;
  localparam logic [2:0] STAT_OK       = 3'd1;
  localparam logic [2:0] STAT_NOCHANGE = 3'd2;
  localparam logic [2:0] STAT_TIMEOUT  = 3'd3;
  localparam logic [2:0] STAT_MISMATCH = 3'd4;
  localparam logic [2:0] STAT_ABORTED  = 3'd5;

  localparam logic [5:0] L0_LTSSM = 6'h16;

  localparam logic       SPD_2G5 = 1'b0;
  localparam logic       SPD_5G0 = 1'b1;
  localparam logic [1:0] WID_X1  = 2'b00;
  localparam logic [1:0] WID_X2  = 2'b01;
  localparam logic [1:0] WID_X4  = 2'b10;
  localparam logic [1:0] WID_X8  = 2'b11;

endpackage

// File: rtl/pcie_link_change_ctrl.sv
// Sequences a directed PCIe speed/width change: waits for L0, drives the core
// handshake, lets the link settle, verifies the result and retries on failure.
module pcie_link_change_ctrl
  import pcie_link_pkg::*;
#(
  parameter logic [5:0] L0_STATE       = L0_LTSSM,
  parameter int         TIMEOUT_CYCLES = 125_000_000,
  parameter int         SETTLE_CYCLES  = 1024,
  parameter int         MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       sys_rst,
  input  logic       req,
  input  logic       req_speed,
  input  logic [1:0] req_width,
  input  logic       abort,
  input  logic       user_lnk_up,
  input  logic [5:0] pl_ltssm_state,
  input  logic       pl_sel_lnk_rate,
  input  logic [1:0] pl_sel_lnk_width,
  input  logic       pl_directed_change_done,
  output logic [1:0] pl_directed_link_change,
  output logic       pl_directed_link_speed,
  output logic [1:0] pl_directed_link_width,
  output logic       pl_directed_link_auton,
  output logic       busy,
  output logic       done,
  output logic [2:0] status,
  output logic [3:0] retry_cnt
);

  localparam int TMAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] SET_LAST  = TW'(SETTLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_LIM = 4'(MAX_RETRY);

  lc_state_t   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic        tgt_spd_q, tgt_spd_d;
  logic [1:0]  tgt_wid_q, tgt_wid_d;
  logic [3:0]  retry_q, retry_d;
  logic [2:0]  status_q, status_d;
  logic        done_q, done_d;
  logic [1:0]  chg_q, chg_d;
  logic        dspd_q, dspd_d;
  logic [1:0]  dwid_q, dwid_d;
  logic        fin;
  logic [2:0]  fin_code;
  logic        link_matches;
  logic        in_l0;

  assign link_matches = (pl_sel_lnk_rate == tgt_spd_q) && (pl_sel_lnk_width == tgt_wid_q);
  assign in_l0        = user_lnk_up && (pl_ltssm_state == L0_STATE);

  always_comb begin
    state_d   = state_q;
    tgt_spd_d = tgt_spd_q;
    tgt_wid_d = tgt_wid_q;
    retry_d   = retry_q;
    status_d  = status_q;
    done_d    = 1'b0;
    chg_d     = chg_q;
    dspd_d    = dspd_q;
    dwid_d    = dwid_q;
    fin       = 1'b0;
    fin_code  = STAT_NONE;

    // Abort outranks every other event while a request is in flight
    if (abort && (state_q != ST_IDLE)) begin
      fin      = 1'b1;
      fin_code = STAT_ABORTED;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            tgt_spd_d = req_speed;
            tgt_wid_d = req_width;
            retry_d   = 4'd0;
            status_d  = STAT_NONE;
            if ((req_speed == pl_sel_lnk_rate) && (req_width == pl_sel_lnk_width)) begin
              done_d   = 1'b1;
              status_d = STAT_NOCHANGE;
            end else begin
              state_d = ST_WAIT_L0;
            end
          end
        end
        ST_WAIT_L0: begin
          if (in_l0) begin
            state_d = ST_ASSERT;
            chg_d   = {tgt_spd_q != pl_sel_lnk_rate, tgt_wid_q != pl_sel_lnk_width};
            dspd_d  = tgt_spd_q;
            dwid_d  = tgt_wid_q;
          end else if (timer_q == TO_LAST) begin
            fin      = 1'b1;
            fin_code = STAT_TIMEOUT;
          end
        end
        ST_ASSERT: begin
          if (pl_directed_change_done) begin
            state_d = ST_SETTLE;
            chg_d   = 2'b00;
            dspd_d  = 1'b0;
            dwid_d  = 2'b00;
          end else if (!user_lnk_up || (timer_q == TO_LAST)) begin
            chg_d  = 2'b00;
            dspd_d = 1'b0;
            dwid_d = 2'b00;
            if (retry_q < RETRY_LIM) begin
              retry_d = retry_q + 4'd1;
              state_d = ST_WAIT_L0;
            end else begin
              fin      = 1'b1;
              fin_code = STAT_TIMEOUT;
            end
          end
        end
        ST_SETTLE: begin
          if (timer_q == SET_LAST) state_d = ST_CHECK;
        end
        ST_CHECK: begin
          if (link_matches) begin
            fin      = 1'b1;
            fin_code = STAT_OK;
          end else if (retry_q < RETRY_LIM) begin
            retry_d = retry_q + 4'd1;
            state_d = ST_WAIT_L0;
          end else begin
            fin      = 1'b1;
            fin_code = STAT_MISMATCH;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (fin) begin
      state_d  = ST_IDLE;
      status_d = fin_code;
      done_d   = 1'b1;
      chg_d    = 2'b00;
      dspd_d   = 1'b0;
      dwid_d   = 2'b00;
    end

    // One shared timer: restarts on any state change, runs in the timed states
    if (state_d != state_q)
      timer_d = '0;
    else if ((state_q == ST_WAIT_L0) || (state_q == ST_ASSERT) || (state_q == ST_SETTLE))
      timer_d = timer_q + TW'(1);
    else
      timer_d = '0;
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      tgt_spd_q <= SPD_2G5;
      tgt_wid_q <= WID_X1;
      retry_q   <= 4'd0;
      status_q  <= STAT_NONE;
      done_q    <= 1'b0;
      chg_q     <= 2'b00;
      dspd_q    <= 1'b0;
      dwid_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      tgt_spd_q <= tgt_spd_d;
      tgt_wid_q <= tgt_wid_d;
      retry_q   <= retry_d;
      status_q  <= status_d;
      done_q    <= done_d;
      chg_q     <= chg_d;
      dspd_q    <= dspd_d;
      dwid_q    <= dwid_d;
    end
  end

  assign pl_directed_link_change = chg_q;
  assign pl_directed_link_speed  = dspd_q;
  assign pl_directed_link_width  = dwid_q;
  assign pl_directed_link_auton  = 1'b0;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign status    = status_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pcie_link_change_ctrl.sv
// Directed bench for pcie_link_change_ctrl: vector table plus multi-cycle sequences.
module tb_pcie_link_change_ctrl;
  import pcie_link_pkg::*;

  logic       clk = 1'b0;
  logic       sys_rst;
  logic       req;
  logic       req_speed;
  logic [1:0] req_width;
  logic       abort;
  logic       user_lnk_up;
  logic [5:0] pl_ltssm_state;
  logic       pl_sel_lnk_rate;
  logic [1:0] pl_sel_lnk_width;
  logic       pl_directed_change_done;
  logic [1:0] pl_directed_link_change;
  logic       pl_directed_link_speed;
  logic [1:0] pl_directed_link_width;
  logic       pl_directed_link_auton;
  logic       busy;
  logic       done;
  logic [2:0] status;
  logic [3:0] retry_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pcie_link_change_ctrl #(
    .TIMEOUT_CYCLES(100),
    .SETTLE_CYCLES (1024),
    .MAX_RETRY     (3)
  ) dut (
    .clk                    (clk),
    .sys_rst                (sys_rst),
    .req                    (req),
    .req_speed              (req_speed),
    .req_width              (req_width),
    .abort                  (abort),
    .user_lnk_up            (user_lnk_up),
    .pl_ltssm_state         (pl_ltssm_state),
    .pl_sel_lnk_rate        (pl_sel_lnk_rate),
    .pl_sel_lnk_width       (pl_sel_lnk_width),
    .pl_directed_change_done(pl_directed_change_done),
    .pl_directed_link_change(pl_directed_link_change),
    .pl_directed_link_speed (pl_directed_link_speed),
    .pl_directed_link_width (pl_directed_link_width),
    .pl_directed_link_auton (pl_directed_link_auton),
    .busy                   (busy),
    .done                   (done),
    .status                 (status),
    .retry_cnt              (retry_cnt)
  );

  typedef struct {
    logic       cur_rate;
    logic [1:0] cur_wid;
    logic       r_spd;
    logic [1:0] r_wid;
    logic       exp_nc;
    logic [1:0] exp_chg;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic link(input logic up, input logic rate, input logic [1:0] wid);
    user_lnk_up      = up;
    pl_ltssm_state   = up ? L0_LTSSM : 6'h00;
    pl_sel_lnk_rate  = rate;
    pl_sel_lnk_width = wid;
  endtask

  task automatic issue(input logic spd, input logic [1:0] wid);
    req       = 1'b1;
    req_speed = spd;
    req_width = wid;
    tick();
    req = 1'b0;
  endtask

  initial begin
    int n;
    int cyc;
    int phases;
    int bad_chg;
    logic act_q;
    logic prev;
    logic seen;

    //           rate  wid    spd   wid    nochg change
    vecs[0] = '{1'b1, 2'b11, 1'b1, 2'b11, 1'b1, 2'b00};
    vecs[1] = '{1'b1, 2'b11, 1'b0, 2'b11, 1'b0, 2'b10};
    vecs[2] = '{1'b1, 2'b11, 1'b1, 2'b10, 1'b0, 2'b01};
    vecs[3] = '{1'b0, 2'b00, 1'b1, 2'b11, 1'b0, 2'b11};
    vecs[4] = '{1'b0, 2'b01, 1'b0, 2'b01, 1'b1, 2'b00};
    vecs[5] = '{1'b0, 2'b10, 1'b0, 2'b00, 1'b0, 2'b01};

    sys_rst = 1'b1;
    req = 1'b0; req_speed = 1'b0; req_width = 2'b00;
    abort = 1'b0; pl_directed_change_done = 1'b0;
    link(1'b0, 1'b0, 2'b00);
    #1;
    chk("rst_busy",   32'(busy), 32'd0);
    chk("rst_done",   32'(done), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_retry",  32'(retry_cnt), 32'd0);
    chk("rst_change", 32'(pl_directed_link_change), 32'd0);
    tick(); tick();
    sys_rst = 1'b0;
    tick();
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Table: immediate response to a request, then ASSERT outputs, then abort
    for (int i = 0; i < 6; i++) begin
      link(1'b1, vecs[i].cur_rate, vecs[i].cur_wid);
      issue(vecs[i].r_spd, vecs[i].r_wid);
      chk($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].exp_nc));
      chk($sformatf("v%0d_status", i), 32'(status), vecs[i].exp_nc ? 32'd2 : 32'd0);
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(!vecs[i].exp_nc));
      if (vecs[i].exp_nc) begin
        tick();
        chk($sformatf("v%0d_nc_busy", i), 32'(busy), 32'd0);
        chk($sformatf("v%0d_nc_done", i), 32'(done), 32'd0);
        chk($sformatf("v%0d_nc_chg", i), 32'(pl_directed_link_change), 32'd0);
      end else begin
        tick();
        chk($sformatf("v%0d_chg", i), 32'(pl_directed_link_change), 32'(vecs[i].exp_chg));
        chk($sformatf("v%0d_spd", i), 32'(pl_directed_link_speed), 32'(vecs[i].r_spd));
        chk($sformatf("v%0d_wid", i), 32'(pl_directed_link_width), 32'(vecs[i].r_wid));
        chk($sformatf("v%0d_auton", i), 32'(pl_directed_link_auton), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk($sformatf("v%0d_ab_status", i), 32'(status), 32'd5);
        chk($sformatf("v%0d_ab_done", i), 32'(done), 32'd1);
        chk($sformatf("v%0d_ab_chg", i), 32'(pl_directed_link_change), 32'd0);
        chk($sformatf("v%0d_ab_busy", i), 32'(busy), 32'd0);
      end
    end

    // Successful speed drop with 20-cycle handshake and full settle
    link(1'b1, 1'b1, 2'b11);
    issue(1'b0, 2'b11);
    tick();
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (pl_directed_link_change == 2'b10 && !pl_directed_link_speed && pl_directed_link_width == 2'b11)
        n++;
      if (c == 19) begin
        pl_directed_change_done = 1'b1;
        pl_sel_lnk_rate = 1'b0;
      end
      tick();
    end
    pl_directed_change_done = 1'b0;
    chk("ok_assert_cycles", 32'(n), 32'd20);
    chk("ok_chg_cleared", 32'(pl_directed_link_change), 32'd0);
    chk("ok_busy_settle", 32'(busy), 32'd1);
    cyc = 0;
    while (!done && cyc < 3000) begin
      tick();
      cyc++;
    end
    chk("ok_settle_latency", 32'(cyc), 32'd1025);
    chk("ok_status", 32'(status), 32'd1);
    chk("ok_retry", 32'(retry_cnt), 32'd0);
    chk("ok_busy", 32'(busy), 32'd0);
    tick();
    chk("ok_done_pulse", 32'(done), 32'd0);

    // Width never changes: four ASSERT phases then MISMATCH
    link(1'b1, 1'b1, 2'b11);
    issue(1'b1, 2'b10);
    phases = 0; bad_chg = 0; prev = 1'b0; cyc = 0;
    while (!done && cyc < 8000) begin
      act_q = (pl_directed_link_change != 2'b00);
      if (act_q && !prev) begin
        phases++;
        if (pl_directed_link_change != 2'b01 || pl_directed_link_width != 2'b10) bad_chg++;
      end
      prev = act_q;
      pl_directed_change_done = act_q;
      tick();
      cyc++;
    end
    pl_directed_change_done = 1'b0;
    chk("mm_finished", 32'(done), 32'd1);
    chk("mm_phases", 32'(phases), 32'd4);
    chk("mm_phase_outputs", 32'(bad_chg), 32'd0);
    chk("mm_status", 32'(status), 32'd4);
    chk("mm_retry", 32'(retry_cnt), 32'd3);
    tick();

    // Link never comes up: timeout out of WAIT_L0
    link(1'b0, 1'b1, 2'b11);
    issue(1'b0, 2'b11);
    cyc = 0; seen = 1'b0;
    while (!done && cyc < 300) begin
      tick();
      cyc++;
      if (pl_directed_link_change != 2'b00 || pl_directed_link_speed || pl_directed_link_width != 2'b00)
        seen = 1'b1;
    end
    chk("to_latency", 32'(cyc), 32'd101);
    chk("to_status", 32'(status), 32'd3);
    chk("to_never_driven", 32'(seen), 32'd0);
    chk("to_retry", 32'(retry_cnt), 32'd0);
    tick();

    // Requests while busy are ignored; abort beats change_done
    link(1'b1, 1'b1, 2'b11);
    req = 1'b1; req_speed = 1'b0; req_width = 2'b11;
    tick();
    req_speed = 1'b1; req_width = 2'b00;
    tick();
    req = 1'b0;
    chk("ig_chg", 32'(pl_directed_link_change), 32'd2);
    chk("ig_spd", 32'(pl_directed_link_speed), 32'd0);
    chk("ig_wid", 32'(pl_directed_link_width), 32'd3);
    issue(1'b1, 2'b00);
    chk("ig_wid_hold", 32'(pl_directed_link_width), 32'd3);
    chk("ig_chg_hold", 32'(pl_directed_link_change), 32'd2);
    abort = 1'b1;
    pl_directed_change_done = 1'b1;
    tick();
    abort = 1'b0;
    pl_directed_change_done = 1'b0;
    chk("ab_status", 32'(status), 32'd5);
    chk("ab_done", 32'(done), 32'd1);
    chk("ab_chg", 32'(pl_directed_link_change), 32'd0);
    chk("ab_busy", 32'(busy), 32'd0);
    tick();
    chk("ab_no_settle", 32'(busy), 32'd0);
    chk("ab_done_pulse", 32'(done), 32'd0);

    // Asynchronous reset in the middle of ASSERT
    link(1'b1, 1'b1, 2'b11);
    issue(1'b0, 2'b11);
    tick();
    chk("rs_pre_chg", 32'(pl_directed_link_change), 32'd2);
    #2;
    sys_rst = 1'b1;
    #1;
    chk("rs_async_chg", 32'(pl_directed_link_change), 32'd0);
    chk("rs_async_wid", 32'(pl_directed_link_width), 32'd0);
    chk("rs_async_busy", 32'(busy), 32'd0);
    chk("rs_async_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    sys_rst = 1'b0;
    tick();
    chk("rs_busy", 32'(busy), 32'd0);
    chk("rs_status", 32'(status), 32'd0);
    chk("rs_done", 32'(done), 32'd0);
    issue(1'b1, 2'b10);
    chk("rs_new_busy", 32'(busy), 32'd1);
    tick();
    chk("rs_new_chg", 32'(pl_directed_link_change), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("rs_new_abort", 32'(status), 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
